// File: rtl/lc3b_pkg.sv
// Shared types and constants for the LC-3b memory responder slice.
package lc3b_pkg;

    localparam int unsigned LatencyDefault = 2;
    localparam int unsigned WordWidth      = 16;
    localparam int unsigned ByteWidth      = 8;
    // Wide enough for the largest legal latency (15).
    localparam int unsigned CntWidth       = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp,
        StHold
    } state_e;

endpackage

// File: rtl/mem_responder_if.sv
// Control-path <-> memory handshake bundle.
interface mem_responder_if;
    import lc3b_pkg::*;

    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_byte;
    logic [15:0]          addr;
    logic [WordWidth-1:0] wdata;
    logic                 mem_ready;
    logic [WordWidth-1:0] rdata;
    logic                 busy;

    modport master (
        output mem_req, mem_we, mem_byte, addr, wdata,
        input  mem_ready, rdata, busy
    );

    modport slave (
        input  mem_req, mem_we, mem_byte, addr, wdata,
        output mem_ready, rdata, busy
    );

endinterface

// File: rtl/mem_array.sv
// Word-organised storage: synchronous per-byte write, combinational read, never reset.
module mem_array
    import lc3b_pkg::*;
#(
    parameter int unsigned AWORDS_LOG2 = 8
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [1:0]             be,
    input  logic [AWORDS_LOG2-1:0] widx,
    input  logic [WordWidth-1:0]   wdata,
    output logic [WordWidth-1:0]   rdata
);

    localparam int unsigned Depth = 1 << AWORDS_LOG2;

    logic [WordWidth-1:0] mem [Depth];

    // Byte-lane writes; the lane not enabled keeps its old contents.
    always_ff @(posedge clk) begin
        if (we && be[0]) begin
            mem[widx][ByteWidth-1:0] <= wdata[ByteWidth-1:0];
        end
        if (we && be[1]) begin
            mem[widx][WordWidth-1:ByteWidth] <= wdata[WordWidth-1:ByteWidth];
        end
    end

    assign rdata = mem[widx];

endmodule

// File: rtl/mem_responder.sv
// Latency-modelling memory responder: FSM, latency counter and request capture.
// RESP is the array access cycle; the completion strobe, read data and the
// write commit all land on the edge leaving RESP, so mem_ready rises
// LATENCY+1 edges after the accepting edge.
module mem_responder
    import lc3b_pkg::*;
#(
    parameter int unsigned LATENCY     = LatencyDefault,
    parameter int unsigned AWORDS_LOG2 = 8
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    state_e                 state_q;
    logic [CntWidth-1:0]    cnt_q;
    logic [AWORDS_LOG2:0]   addr_q;
    logic [WordWidth-1:0]   wdata_q;
    logic                   we_q;
    logic                   byte_q;
    logic                   mem_ready_q;
    logic [WordWidth-1:0]   rdata_q;
    logic                   busy_q;

    logic                   arr_we;
    logic [1:0]             arr_be;
    logic [WordWidth-1:0]   arr_wdata;
    logic [WordWidth-1:0]   arr_rdata;
    logic [WordWidth-1:0]   rd_fmt;

    // Write lanes and data steering for the captured request.
    always_comb begin
        arr_we    = (state_q == StResp) && we_q;
        arr_be    = 2'b11;
        arr_wdata = wdata_q;
        if (byte_q) begin
            arr_be    = addr_q[0] ? 2'b10 : 2'b01;
            arr_wdata = {wdata_q[ByteWidth-1:0], wdata_q[ByteWidth-1:0]};
        end
    end

    // Byte reads return the selected byte zero-extended; sign extension is the datapath's job.
    always_comb begin
        rd_fmt = arr_rdata;
        if (byte_q) begin
            rd_fmt = {{(WordWidth-ByteWidth){1'b0}},
                      addr_q[0] ? arr_rdata[WordWidth-1:ByteWidth]
                                : arr_rdata[ByteWidth-1:0]};
        end
    end

    mem_array #(
        .AWORDS_LOG2 (AWORDS_LOG2)
    ) u_mem_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (arr_be),
        .widx  (addr_q[AWORDS_LOG2:1]),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // Request FSM with latency counter, capture registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            byte_q      <= 1'b0;
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
        end else begin
            mem_ready_q <= 1'b0;
            rdata_q     <= '0;
            case (state_q)
                StIdle: begin
                    if (bus.mem_req) begin
                        state_q <= StWait;
                        cnt_q   <= CntWidth'(LATENCY - 1);
                        addr_q  <= bus.addr[AWORDS_LOG2:0];
                        wdata_q <= bus.wdata;
                        we_q    <= bus.mem_we;
                        byte_q  <= bus.mem_byte;
                        busy_q  <= 1'b1;
                    end
                end
                StWait: begin
                    if (!bus.mem_req) begin
                        // Abort: nothing was written and no strobe is produced.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q     <= StHold;
                    mem_ready_q <= 1'b1;
                    rdata_q     <= we_q ? '0 : rd_fmt;
                end
                StHold: begin
                    // Wait for the request to drop so it is never served twice.
                    if (!bus.mem_req) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_ready = mem_ready_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder against a word-array reference model.
module tb_mem_responder;
    import lc3b_pkg::*;

    localparam int unsigned Lat   = 2;
    localparam int unsigned Awl   = 8;
    localparam int unsigned Depth = 1 << Awl;

    logic clk = 1'b0;
    logic reset;

    mem_responder_if bus ();

    mem_responder #(
        .LATENCY     (Lat),
        .AWORDS_LOG2 (Awl)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [15:0] model [Depth];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest expected response, in data and timing.
    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.mem_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_ready: got mem_ready=1 at cycle %0d expected no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ready_cycle", 32'(cyc), 32'(mon_e.due));
                if (mon_e.is_read) check("rdata", 32'(bus.rdata), 32'(mon_e.data));
            end
        end else begin
            check("rdata_zero_when_idle", 32'(bus.rdata), 32'h0);
        end
    end

    // Issue one request starting just after a clock edge with the responder idle.
    task automatic txn(input bit we, input bit bt, input logic [15:0] a, input logic [15:0] wd,
                       input int hold_extra, input int abort_after, input bit scramble);
        int   ix;
        bit   seen;
        exp_t e;
        ix           = int'(a[Awl:1]);
        bus.mem_we   = we;
        bus.mem_byte = bt;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.mem_req  = 1'b1;
        if (abort_after > 0) begin
            repeat (abort_after) @(posedge clk);
            #1 bus.mem_req = 1'b0;
            @(posedge clk);
            #1 check("busy_after_abort", 32'(bus.busy), 32'h0);
            return;
        end
        e.is_read = !we;
        e.due     = cyc + 1 + Lat + 1;
        if (bt) e.data = {8'h00, a[0] ? model[ix][15:8] : model[ix][7:0]};
        else    e.data = model[ix];
        if (we) begin
            if (!bt)      model[ix]       = wd;
            else if (a[0]) model[ix][15:8] = wd[7:0];
            else          model[ix][7:0]  = wd[7:0];
        end
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready === 1'b1) begin
                seen = 1'b1;
            end else if (scramble) begin
                bus.mem_we   = 1'($urandom);
                bus.mem_byte = 1'($urandom);
                bus.addr     = 16'($urandom);
                bus.wdata    = 16'($urandom);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got no mem_ready within 40 cycles expected one");
        end
        for (int j = 0; j < hold_extra; j++) begin
            @(posedge clk);
            #1 check("busy_in_hold", 32'(bus.busy), 32'h1);
        end
        bus.mem_req = 1'b0;
        @(posedge clk);
        #1 check("busy_after_release", 32'(bus.busy), 32'h0);
    endtask

    // Word write that is killed by an asynchronous reset while in the response cycle.
    task automatic reset_in_resp(input logic [15:0] a, input logic [15:0] wd);
        bus.mem_we   = 1'b1;
        bus.mem_byte = 1'b0;
        bus.addr     = a;
        bus.wdata    = wd;
        bus.mem_req  = 1'b1;
        repeat (Lat + 1) @(posedge clk);
        #1 check("busy_before_reset", 32'(bus.busy), 32'h1);
        #1 reset = 1'b0;
        #1;
        check("reset_mid_ready", 32'(bus.mem_ready), 32'h0);
        check("reset_mid_busy", 32'(bus.busy), 32'h0);
        check("reset_mid_rdata", 32'(bus.rdata), 32'h0);
        bus.mem_req = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_byte = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;
        #3;
        check("reset_ready", 32'(bus.mem_ready), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_rdata", 32'(bus.rdata), 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        // Give every word a known value.
        for (int i = 0; i < int'(Depth); i++) begin
            txn(1'b1, 1'b0, 16'(i << 1), 16'($urandom), 0, 0, 1'b0);
        end

        // Word write then read.
        txn(1'b1, 1'b0, 16'h0010, 16'hBEEF, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0, 1'b0);
        // High-byte store, word read back, byte load.
        txn(1'b1, 1'b1, 16'h0011, 16'h0042, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 0, 0, 1'b0);
        txn(1'b0, 1'b1, 16'h0011, 16'h0000, 0, 0, 1'b0);
        txn(1'b0, 1'b1, 16'h0010, 16'h0000, 0, 0, 1'b0);
        // Aborted writes at both ends of the wait window.
        txn(1'b1, 1'b0, 16'h0020, 16'h1234, 0, 1, 1'b0);
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0, 1'b0);
        txn(1'b1, 1'b0, 16'h0020, 16'h5678, 0, int'(Lat), 1'b0);
        txn(1'b0, 1'b0, 16'h0020, 16'h0000, 0, 0, 1'b0);
        // Request held well past the strobe.
        txn(1'b0, 1'b0, 16'h0010, 16'h0000, 4, 0, 1'b0);
        // Reset during the response cycle discards the write.
        reset_in_resp(16'h0030, 16'hDEAD);
        txn(1'b0, 1'b0, 16'h0030, 16'h0000, 0, 0, 1'b0);
        // Address wrap with odd byte address on a word access.
        txn(1'b1, 1'b0, 16'h0201, 16'hA5A5, 0, 0, 1'b0);
        txn(1'b0, 1'b0, 16'h0000, 16'h0000, 0, 0, 1'b0);
        // Inputs changed after acceptance must not matter.
        txn(1'b1, 1'b1, 16'h0040, 16'h00C3, 0, 0, 1'b1);
        txn(1'b0, 1'b0, 16'h0040, 16'h0000, 0, 0, 1'b1);

        for (int n = 0; n < 200; n++) begin
            int ab;
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, Lat)) : 0;
            txn(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, 3)), ab, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
